// File: rtl/tx_engine.sv
// ----------------------------------------------------------------------------
// tx_engine -- asynchronous serial transmitter (UART TX).
//
// Sends one character per load as: start bit (0), 7 or 8 data bits LSB
// first, optional even/odd parity bit, stop bit(s) (1). Each bit lasts
// k+1 clk cycles. Character and framing options are captured when the load
// is accepted, so later input changes do not disturb the frame in flight.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   load     in   1   single-cycle write strobe (accepted only when TXRDY=1)
//   out_port in   8   character to transmit
//   eight    in   1   1 = 8 data bits, 0 = 7 data bits (out_port[7] ignored)
//   pen      in   1   1 = append parity bit
//   even     in   1   1 = even parity, 0 = odd parity
//   k        in  19   baud divisor, bit period = k+1 cycles (sampled live)
//   tx       out  1   serial line, idle high
//   TXRDY    out  1   1 = idle, able to accept load
//
// Configuration macro:
//   TX_TWO_STOP_EN  defined   -> two stop bits, 12-bit shift register
//                   undefined -> one stop bit, 11-bit shift register
// ----------------------------------------------------------------------------
module tx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  out_port,
    input  logic        eight,
    input  logic        pen,
    input  logic        even,
    input  logic [18:0] k,
    output logic        tx,
    output logic        TXRDY
);

`ifdef TX_TWO_STOP_EN
    localparam int unsigned SW    = 12;
    localparam int unsigned NSTOP = 2;
`else
    localparam int unsigned SW    = 11;
    localparam int unsigned NSTOP = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [SW-1:0] shreg;
    logic [18:0]   bit_time;
    logic [3:0]    bit_cnt;

    logic [7:0]    hold_data;
    logic          hold_eight;
    logic          hold_pen;
    logic          hold_even;

    logic [3:0]    frame_len;
    logic [SW-1:0] frame;
    logic          parity;
    logic          bit_done;
    logic          frame_done;

    // Frame length: start + 7 data + stop(s), plus one each for 8th bit and parity.
    always_comb begin
        frame_len = 4'd8 + 4'(NSTOP) + {3'b000, hold_eight} + {3'b000, hold_pen};
    end

    // Parity over transmitted data bits only; bit 7 is masked off in 7-bit mode.
    always_comb begin
        parity = (^(hold_data & {hold_eight, 7'h7F})) ^ ~hold_even;
    end

    // Frame image, bit 0 goes out first; unused upper bits act as stop/idle ones.
    always_comb begin
        frame    = '1;
        frame[0] = 1'b0;
        if (hold_eight) begin
            frame[8:1] = hold_data;
            if (hold_pen) begin
                frame[9] = parity;
            end
        end else begin
            frame[7:1] = hold_data[6:0];
            if (hold_pen) begin
                frame[8] = parity;
            end
        end
    end

    // '>=' keeps the counter bounded by k even if k is lowered mid-bit.
    always_comb begin
        bit_done   = (bit_time >= k);
        frame_done = bit_done && (bit_cnt == 4'(frame_len - 4'd1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs (Moore)
    always_comb begin
        TXRDY = (state == IDLE);
        tx    = (state == SEND) ? shreg[0] : 1'b1;
    end

    // Datapath: hold register, shift register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_eight <= 1'b0;
            hold_pen   <= 1'b0;
            hold_even  <= 1'b0;
            shreg      <= '1;
            bit_time   <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_time <= '0;
                    bit_cnt  <= '0;
                    if (load) begin
                        hold_data  <= out_port;
                        hold_eight <= eight;
                        hold_pen   <= pen;
                        hold_even  <= even;
                    end
                end
                LOAD: begin
                    shreg    <= frame;
                    bit_time <= '0;
                    bit_cnt  <= '0;
                end
                SEND: begin
                    if (bit_done) begin
                        bit_time <= '0;
                        shreg    <= {1'b1, shreg[SW-1:1]};
                        bit_cnt  <= frame_done ? 4'd0 : bit_cnt + 4'd1;
                    end else begin
                        bit_time <= bit_time + 19'd1;
                    end
                end
                default: begin
                    bit_time <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_engine.md
TX_ENGINE -- requirements
Module: tx_engine

Interface
REQ-001 SHALL have: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: load  in  1  single-cycle write strobe for out_port.
REQ-004 SHALL have: out_port  in  8  character to transmit.
REQ-005 SHALL have: eight  in  1  1 = 8 data bits, 0 = 7 data bits (out_port[7] ignored).
REQ-006 SHALL have: pen  in  1  1 = parity bit appended.
REQ-007 SHALL have: even  in  1  1 = even parity, 0 = odd parity.
REQ-008 SHALL have: k  in  19  baud divisor; bit period = k+1 clk cycles.
REQ-009 SHALL have: tx  out  1  serial line, idle high.
REQ-010 SHALL have: TXRDY  out  1  1 = idle, able to accept load.

Function
REQ-011 Frame order SHALL be: start (0), data LSB first (7 or 8 bits), parity if pen, stop (1).
REQ-012 Parity bit SHALL be XOR of transmitted data bits when even=1, and its inverse when even=0.
REQ-013 Frame length SHALL be: 7N=9, 7P/8N=10, 8P=11 bit periods, each exactly k+1 cycles (k=0 gives 1 cycle per bit).
REQ-014 States SHALL be IDLE, LOAD, SEND.
REQ-015 IDLE: tx=1, TXRDY=1; load=1 moves to LOAD.
REQ-016 Capture in IDLE on load: out_port, eight, pen and even SHALL be captured into a hold register; changes to these inputs afterwards SHALL not affect the frame.
REQ-017 LOAD SHALL last one cycle and build the frame into an 11-bit shift register (unused upper bits = 1), then move to SEND.
REQ-018 SEND: tx SHALL equal shift register bit 0.
REQ-019 SEND: a 19-bit bit-time counter SHALL count 0..k; at k it clears, the shift register shifts right filling 1, and a 4-bit bit counter increments.
REQ-020 SEND SHALL exit to IDLE when the bit counter reaches the frame length; tx=1 in IDLE.
REQ-021 TXRDY SHALL deassert on the cycle after an accepted load and reassert on the IDLE entry.
REQ-022 Latency: load sampled at edge N gives tx=0 from edge N+2; TXRDY=1 from edge N+2+frame_length*(k+1).
REQ-023 load while TXRDY=0 SHALL be ignored with no effect on the current frame.
REQ-024 load in the first IDLE cycle after a frame SHALL be accepted (back-to-back frames, no extra idle).
REQ-025 k SHALL be sampled live; changing it mid-frame is unsupported, but the counter SHALL never exceed 2^19-1 and SHALL not wrap.

Reset
REQ-026 rst SHALL immediately force: state=IDLE, tx=1, TXRDY=1, all counters=0, shift register=all ones, hold register=0.
REQ-027 rst mid-frame SHALL abort the frame; no partial resumption after release.

Configuration
REQ-028 Macro TX_TWO_STOP_EN SHALL select the stop-bit count.
REQ-029 With TX_TWO_STOP_EN defined: two stop bits are sent and frame lengths in REQ-013 increase by one (max 12, shift register widened to 12 bits).
REQ-030 Without TX_TWO_STOP_EN: one stop bit is sent, exactly per REQ-013.

Verification
REQ-031 8N1, k=3, load 0x55 at cycle 0 -> tx 0,1,0,1,0,1,0,1,0,1, each 4 cycles from cycle 2; TXRDY=0 cycles 1..41, =1 at 42.
REQ-032 8E1, k=0, load 0x03 -> tx 0,1,1,0,0,0,0,0,0,P=0,1; TXRDY back at cycle 13.
REQ-033 7O1, k=1, load 0xC1 -> data 1,0,0,0,0,0,1 (bit7 ignored), parity 1, stop 1; 10 bit periods of 2 cycles.
REQ-034 Busy test: load 0xAA, then load 0xFF mid-frame -> frame carries 0xAA only; TXRDY timing unchanged.
REQ-035 rst asserted mid-data bit -> tx=1, TXRDY=1 same cycle; after release, load 0x0F sends a clean full frame.
REQ-036 TX_TWO_STOP_EN build, 8N, k=0, back-to-back 0x00,0xFF -> stop lasts 2 cycles between frames; second start follows immediately.
